// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a 1-bit ALU slice: one operand bit per clock, LSB first,
// with the slice carry fed back; SLT adds a second pass that routes the sign result through Less.
module alu_serial_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_binvert,
  output logic             slice_less,
  output logic [2:0]       slice_op,
  input  logic             slice_rez,
  input  logic             slice_cout,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  localparam logic [2:0] F_AND = 3'd0;
  localparam logic [2:0] F_OR  = 3'd1;
  localparam logic [2:0] F_XOR = 3'd2;
  localparam logic [2:0] F_ADD = 3'd3;
  localparam logic [2:0] F_SUB = 3'd4;
  localparam logic [2:0] F_SLT = 3'd5;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_LESS = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LESS_RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       func_q, func_d;
  logic             carry_q, carry_d;
  logic             set_q, set_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic isArith;
  logic isInvert;

  assign isArith  = (func_q == F_ADD) || (func_q == F_SUB) || (func_q == F_SLT);
  assign isInvert = (func_q == F_SUB) || (func_q == F_SLT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      func_q      <= F_AND;
      carry_q     <= 1'b0;
      set_q       <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      func_q      <= func_d;
      carry_q     <= carry_d;
      set_q       <= set_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    a_d           = a_q;
    b_d           = b_q;
    func_d        = func_q;
    carry_d       = carry_q;
    set_d         = set_q;
    result_d      = result_q;
    carry_out_d   = carry_out_q;
    overflow_d    = overflow_q;
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_cin     = 1'b0;
    slice_binvert = 1'b0;
    slice_less    = 1'b0;
    slice_op      = OP_AND;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          // Codes 6 and 7 collapse to AND so later decoding only sees legal functions.
          func_d  = (func > F_SLT) ? F_AND : func;
          idx_d   = '0;
          carry_d = (func == F_SUB) || (func == F_SLT);
          state_d = RUN;
        end
      end

      RUN: begin
        slice_a       = a_q[idx_q];
        slice_b       = b_q[idx_q];
        slice_cin     = carry_q;
        slice_binvert = isInvert;
        unique case (func_q)
          F_OR:    slice_op = OP_OR;
          F_XOR:   slice_op = OP_XOR;
          F_ADD,
          F_SUB,
          F_SLT:   slice_op = OP_ADD;
          default: slice_op = OP_AND;
        endcase
        result_d[idx_q] = slice_rez;
        carry_d         = slice_cout;
        if (idx_q == LAST_IDX) begin
          // carry_q is the MSB carry-in here, so carry_q ^ slice_cout is signed overflow.
          if (func_q == F_SLT) begin
            set_d       = slice_rez ^ (carry_q ^ slice_cout);
            overflow_d  = carry_q ^ slice_cout;
            carry_out_d = 1'b0;
            idx_d       = '0;
            state_d     = LESS_RUN;
          end else begin
            carry_out_d = isArith & slice_cout;
            overflow_d  = isArith & (carry_q ^ slice_cout);
            state_d     = DONE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      LESS_RUN: begin
        slice_a         = a_q[idx_q];
        slice_b         = b_q[idx_q];
        slice_op        = OP_LESS;
        slice_less      = (idx_q == '0) ? set_q : 1'b0;
        result_d[idx_q] = slice_rez;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = (result_q == '0);
  assign busy      = (state_q == RUN) || (state_q == LESS_RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized scoreboard bench for alu_serial_seq with a behavioural model of the 1-bit slice.
module tb_alu_serial_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   func;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         slice_a, slice_b, slice_cin, slice_binvert, slice_less;
  logic [2:0]   slice_op;
  logic         slice_rez, slice_cout;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero, busy, done;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .op_a(op_a), .op_b(op_b),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_binvert(slice_binvert), .slice_less(slice_less), .slice_op(slice_op),
    .slice_rez(slice_rez), .slice_cout(slice_cout),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the Alu1bit slice the sequencer controls.
  logic bEff;
  always_comb begin
    bEff       = slice_b ^ slice_binvert;
    slice_cout = (slice_a & bEff) | (slice_a & slice_cin) | (bEff & slice_cin);
    case (slice_op)
      3'b000:  slice_rez = slice_a & bEff;
      3'b010:  slice_rez = slice_a | bEff;
      3'b011:  slice_rez = slice_a ^ bEff;
      3'b100:  slice_rez = slice_a ^ bEff ^ slice_cin;
      3'b101:  slice_rez = slice_less;
      default: slice_rez = 1'b0;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    logic         ov;
    logic         z;
    int           lat;
    int           acceptCyc;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   doneCount = 0;
  int   expectedDones = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference computed from plain integer arithmetic on whole operands.
  function automatic exp_t refModel(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   s;
    logic [2:0]   fe;
    fe = (f > 3'd5) ? 3'd0 : f;
    e.cy = 1'b0;
    e.ov = 1'b0;
    e.lat = W + 1;
    e.acceptCyc = 0;
    case (fe)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: e.res = a ^ b;
      3'd3: begin
        s    = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.cy = s[W];
        e.ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      3'd4: begin
        s    = {1'b0, a} + {1'b0, ~b} + 1;
        e.res = s[W-1:0];
        e.cy = s[W];
        e.ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      default: begin
        s    = {1'b0, a} + {1'b0, ~b} + 1;
        e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        e.ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        e.lat = 2 * W + 1;
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Monitor: compares every completion against the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result", 32'(result), 32'(e.res));
        checkOutput("carry_out", 32'(carry_out), 32'(e.cy));
        checkOutput("overflow", 32'(overflow), 32'(e.ov));
        checkOutput("zero", 32'(zero), 32'(e.z));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        checkOutput("latency", 32'(cyc + 1 - e.acceptCyc), 32'(e.lat));
      end
    end
    if (!busy) begin
      checkOutput("slice_quiet",
                  32'({slice_a, slice_b, slice_cin, slice_binvert, slice_less, slice_op}), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit hold);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("idle_timeout", 32'd1, 32'd0);
    func  = f;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e = refModel(f, a, b);
    e.acceptCyc = cyc;
    expQ.push_back(e);
    expectedDones++;
    if (!hold) begin
      start = 1'b0;
    end else begin
      n = 0;
      do begin
        @(negedge clk);
        op_a = W'($urandom);
        op_b = W'($urandom);
        func = 3'($urandom);
        n++;
      end while (!done && n < 100);
      if (n >= 100) checkOutput("hold_done_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic [2:0] f;
    logic [W-1:0] a, b;
    rst_n = 1'b0;
    start = 1'b0;
    func  = 3'd0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_carry", 32'(carry_out), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    // Reset and start together: reset must win.
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_beats_start", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    applyStimulus(3'd3, 16'h7FFF, 16'h0001, 1'b0);
    applyStimulus(3'd4, 16'h0005, 16'h0005, 1'b0);
    checkOutput("sub_binvert", 32'(slice_binvert), 32'd1);
    checkOutput("sub_first_cin", 32'(slice_cin), 32'd1);
    checkOutput("sub_slice_op", 32'(slice_op), 32'b100);
    applyStimulus(3'd5, 16'hFFFE, 16'h0003, 1'b0);
    applyStimulus(3'd5, 16'h0003, 16'hFFFE, 1'b0);
    applyStimulus(3'd0, 16'hF0F0, 16'hFF00, 1'b0);
    applyStimulus(3'd1, 16'hF0F0, 16'hFF00, 1'b0);
    applyStimulus(3'd2, 16'hF0F0, 16'hFF00, 1'b0);
    applyStimulus(3'd6, 16'h1234, 16'h0FF0, 1'b0);
    applyStimulus(3'd5, 16'h8000, 16'h7FFF, 1'b0);
    applyStimulus(3'd3, 16'h8000, 16'h8000, 1'b1);
    applyStimulus(3'd5, 16'h7FFF, 16'h8000, 1'b1);

    // Reset in the middle of an ADD.
    applyStimulus(3'd3, 16'h1111, 16'h2222, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_zero", 32'(zero), 32'd1);
    checkOutput("midrst_slice",
                32'({slice_a, slice_b, slice_cin, slice_binvert, slice_less, slice_op}), 32'd0);
    expectedDones -= expQ.size();
    expQ.delete();
    rst_n = 1'b1;
    applyStimulus(3'd3, 16'h0002, 16'h0003, 1'b0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
      applyStimulus(f, a, b, ($urandom_range(0, 7) == 0));
    end

    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("done_count", 32'(doneCount), 32'(expectedDones));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
